// File: rtl/decode_stage.sv
// decode_stage: LC-3 pipeline decode stage.
// Captures the fetched instruction and its next-PC when enable_decode is high.
// Decodes the incoming opcode into execute, writeback and memory control words.
// Every output is registered, so no input reaches an output combinationally.
// When enable_decode is low (or unknown) all state holds, which is a stall.
module decode_stage #(
  parameter int              WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable_decode,
  input  logic [WIDTH-1:0] npc_in,
  input  logic [WIDTH-1:0] instr_dout,
  output logic [WIDTH-1:0] IR,
  output logic [WIDTH-1:0] npc_out,
  output logic [5:0]       E_Control,
  output logic [1:0]       W_Control,
  output logic             Mem_Control
);

  // LC-3 opcodes that this stage decodes
  typedef enum logic [3:0] {
    OP_BR  = 4'b0000,
    OP_ADD = 4'b0001,
    OP_LD  = 4'b0010,
    OP_ST  = 4'b0011,
    OP_AND = 4'b0101,
    OP_LDR = 4'b0110,
    OP_STR = 4'b0111,
    OP_NOT = 4'b1001,
    OP_LDI = 4'b1010,
    OP_STI = 4'b1011,
    OP_JMP = 4'b1100,
    OP_LEA = 4'b1110
  } opcode_e;

  // Writeback source selections
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  // pcselect1 offset selections
  localparam logic [1:0] PC1_OFF9 = 2'b01;
  localparam logic [1:0] PC1_OFF6 = 2'b10;
  localparam logic [1:0] PC1_ZERO = 2'b11;

  logic [3:0] opcode;
  logic       imm_mode;
  logic [1:0] alu_control;
  logic [1:0] pcselect1;
  logic       pcselect2;
  logic       op2select;
  logic [5:0] e_next;
  logic [1:0] w_next;
  logic       mem_next;

  assign opcode   = instr_dout[15:12];
  assign imm_mode = instr_dout[5];

  // Decode the incoming instruction word into the next control words
  always_comb begin
    alu_control = 2'b00;
    pcselect1   = 2'b00;
    pcselect2   = 1'b0;
    op2select   = 1'b0;
    w_next      = WB_ALU;
    mem_next    = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_control = 2'b00;
        op2select   = ~imm_mode;
      end
      OP_AND: begin
        alu_control = 2'b01;
        op2select   = ~imm_mode;
      end
      OP_NOT: begin
        alu_control = 2'b10;
      end
      OP_BR, OP_ST: begin
        pcselect1 = PC1_OFF9;
        pcselect2 = 1'b1;
      end
      OP_JMP: begin
        pcselect1 = PC1_ZERO;
      end
      OP_LD: begin
        pcselect1 = PC1_OFF9;
        pcselect2 = 1'b1;
        w_next    = WB_MEM;
      end
      OP_LDR: begin
        pcselect1 = PC1_OFF6;
        w_next    = WB_MEM;
      end
      OP_STR: begin
        pcselect1 = PC1_OFF6;
      end
      OP_LDI: begin
        pcselect1 = PC1_OFF9;
        pcselect2 = 1'b1;
        w_next    = WB_MEM;
        mem_next  = 1'b1;
      end
      OP_STI: begin
        pcselect1 = PC1_OFF9;
        pcselect2 = 1'b1;
        mem_next  = 1'b1;
      end
      OP_LEA: begin
        pcselect1 = PC1_OFF9;
        pcselect2 = 1'b1;
        w_next    = WB_PC;
      end
      default: begin
        alu_control = 2'b00;
      end
    endcase
    e_next = {alu_control, pcselect1, pcselect2, op2select};
  end

  // Register the instruction, next-PC and control words on an enabled edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      IR          <= RESET_VAL;
      npc_out     <= RESET_VAL;
      E_Control   <= 6'b000000;
      W_Control   <= 2'b00;
      Mem_Control <= 1'b0;
    end else if (enable_decode) begin
      IR          <= instr_dout;
      npc_out     <= npc_in;
      E_Control   <= e_next;
      W_Control   <= w_next;
      Mem_Control <= mem_next;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed, table-driven self-checking bench for decode_stage.
// Inputs change on the falling edge; outputs are checked 1 ns after the rising edge.
module tb_decode_stage;

  logic        clock;
  logic        reset;
  logic        enable_decode;
  logic [15:0] npc_in;
  logic [15:0] instr_dout;
  logic [15:0] IR;
  logic [15:0] npc_out;
  logic [5:0]  E_Control;
  logic [1:0]  W_Control;
  logic        Mem_Control;

  int vector_count;
  int miscompare_count;

  typedef struct {
    logic        en;
    logic [15:0] npc;
    logic [15:0] instr;
    logic [15:0] exp_ir;
    logic [15:0] exp_npc;
    logic [5:0]  exp_e;
    logic [1:0]  exp_w;
    logic        exp_mem;
    string       name;
  } vector_t;

  vector_t vectors[$];

  decode_stage #(.WIDTH(16), .RESET_VAL(16'h0000)) dut (
    .clock         (clock),
    .reset         (reset),
    .enable_decode (enable_decode),
    .npc_in        (npc_in),
    .instr_dout    (instr_dout),
    .IR            (IR),
    .npc_out       (npc_out),
    .E_Control     (E_Control),
    .W_Control     (W_Control),
    .Mem_Control   (Mem_Control)
  );

  // 10 ns clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // enable_decode must never be X/Z outside reset
  always @(negedge clock) begin
    if (!reset) begin
      assert (!$isunknown(enable_decode))
        else $error("[TB] protocol error: enable_decode is X/Z");
    end
  end

  // Drive one set of inputs on the falling edge
  task automatic applyStimulus(input logic en, input logic [15:0] npc, input logic [15:0] instr);
    @(negedge clock);
    enable_decode = en;
    npc_in        = npc;
    instr_dout    = instr;
  endtask

  // Compare all outputs against expected values
  task automatic checkOutput(input string name, input logic [15:0] exp_ir, input logic [15:0] exp_npc,
                             input logic [5:0] exp_e, input logic [1:0] exp_w, input logic exp_mem);
    vector_count++;
    if (IR !== exp_ir || npc_out !== exp_npc || E_Control !== exp_e ||
        W_Control !== exp_w || Mem_Control !== exp_mem) begin
      miscompare_count++;
      $display("[TB] FAIL %s: got IR=%h npc=%h E=%b W=%b Mem=%b, expected IR=%h npc=%h E=%b W=%b Mem=%b",
               name, IR, npc_out, E_Control, W_Control, Mem_Control,
               exp_ir, exp_npc, exp_e, exp_w, exp_mem);
    end
  endtask

  task automatic addVector(input logic en, input logic [15:0] npc, input logic [15:0] instr,
                           input logic [15:0] exp_ir, input logic [15:0] exp_npc,
                           input logic [5:0] exp_e, input logic [1:0] exp_w, input logic exp_mem,
                           input string name);
    vector_t v;
    v.en = en; v.npc = npc; v.instr = instr;
    v.exp_ir = exp_ir; v.exp_npc = exp_npc;
    v.exp_e = exp_e; v.exp_w = exp_w; v.exp_mem = exp_mem;
    v.name = name;
    vectors.push_back(v);
  endtask

  initial begin
    vector_count     = 0;
    miscompare_count = 0;
    reset            = 1'b1;
    enable_decode    = 1'b0;
    npc_in           = 16'h0000;
    instr_dout       = 16'h0000;

    // Hand-computed vectors: en, npc, instr -> IR, npc_out, E, W, Mem
    addVector(1, 16'h3001, 16'h1283, 16'h1283, 16'h3001, 6'b000001, 2'b00, 0, "add_reg");
    addVector(1, 16'h3002, 16'h12A5, 16'h12A5, 16'h3002, 6'b000000, 2'b00, 0, "add_imm");
    addVector(1, 16'h3003, 16'h6642, 16'h6642, 16'h3003, 6'b001000, 2'b01, 0, "ldr");
    addVector(1, 16'h3004, 16'hA5FF, 16'hA5FF, 16'h3004, 6'b000110, 2'b01, 1, "ldi");
    addVector(0, 16'h3005, 16'h0000, 16'hA5FF, 16'h3004, 6'b000110, 2'b01, 1, "stall1");
    addVector(0, 16'h3006, 16'h0000, 16'hA5FF, 16'h3004, 6'b000110, 2'b01, 1, "stall2");
    addVector(0, 16'h3007, 16'h0000, 16'hA5FF, 16'h3004, 6'b000110, 2'b01, 1, "stall3");
    addVector(1, 16'h3008, 16'hE1FE, 16'hE1FE, 16'h3008, 6'b000110, 2'b10, 0, "lea");
    addVector(1, 16'h3009, 16'hF025, 16'hF025, 16'h3009, 6'b000000, 2'b00, 0, "trap");
    addVector(1, 16'h300A, 16'h5283, 16'h5283, 16'h300A, 6'b010001, 2'b00, 0, "and_reg");
    addVector(1, 16'h300B, 16'h5060, 16'h5060, 16'h300B, 6'b010000, 2'b00, 0, "and_imm");
    addVector(1, 16'h300C, 16'h9ABF, 16'h9ABF, 16'h300C, 6'b100000, 2'b00, 0, "not");
    addVector(1, 16'h300D, 16'h0E05, 16'h0E05, 16'h300D, 6'b000110, 2'b00, 0, "br");
    addVector(1, 16'h300E, 16'hC1C0, 16'hC1C0, 16'h300E, 6'b001100, 2'b00, 0, "jmp");
    addVector(1, 16'h300F, 16'h2205, 16'h2205, 16'h300F, 6'b000110, 2'b01, 0, "ld");
    addVector(1, 16'h3010, 16'h3205, 16'h3205, 16'h3010, 6'b000110, 2'b00, 0, "st");
    addVector(1, 16'h3011, 16'h7441, 16'h7441, 16'h3011, 6'b001000, 2'b00, 0, "str");
    addVector(1, 16'h3012, 16'hB1FF, 16'hB1FF, 16'h3012, 6'b000110, 2'b00, 1, "sti");
    addVector(1, 16'h3013, 16'h4000, 16'h4000, 16'h3013, 6'b000000, 2'b00, 0, "unsup_4");
    addVector(1, 16'h3014, 16'h8000, 16'h8000, 16'h3014, 6'b000000, 2'b00, 0, "unsup_8");
    addVector(1, 16'h3015, 16'hD123, 16'hD123, 16'h3015, 6'b000000, 2'b00, 0, "unsup_d");
    addVector(0, 16'h3016, 16'h1283, 16'hD123, 16'h3015, 6'b000000, 2'b00, 0, "stall_unsup");

    // Reset, then five idle clocks with no enable
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 16'h1234, 16'h1283);
      @(posedge clock);
      #1;
      checkOutput($sformatf("reset_idle%0d", i), 16'h0000, 16'h0000, 6'b000000, 2'b00, 1'b0);
    end

    // Table-driven vectors, one per clock
    for (int i = 0; i < vectors.size(); i++) begin
      applyStimulus(vectors[i].en, vectors[i].npc, vectors[i].instr);
      @(posedge clock);
      #1;
      checkOutput(vectors[i].name, vectors[i].exp_ir, vectors[i].exp_npc,
                  vectors[i].exp_e, vectors[i].exp_w, vectors[i].exp_mem);
    end

    // Load STI, then assert reset mid-cycle and expect an immediate clear
    applyStimulus(1'b1, 16'h3020, 16'hB1FF);
    @(posedge clock);
    #1;
    checkOutput("sti_before_reset", 16'hB1FF, 16'h3020, 6'b000110, 2'b00, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_clear", 16'h0000, 16'h0000, 6'b000000, 2'b00, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(1'b1, 16'h3021, 16'h1283);
    @(posedge clock);
    #1;
    checkOutput("resume_after_reset", 16'h1283, 16'h3021, 6'b000001, 2'b00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
    $finish;
  end

  // Absolute time bound so the run always terminates
  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not complete, expected completion before 100000 ns");
    $fatal(1, "[TB] timeout");
  end

endmodule
